// File: rtl/modmul_seq_1499_pkg.sv
// Shared constants, FSM encoding and operand range helper for the Q=1499 sequential modular multiplier.
package modmul_seq_1499_pkg;

   localparam int unsigned Q      = 1499;
   localparam int unsigned W      = 11;
   localparam int unsigned STEP_W = W + 2;
   localparam int unsigned CNT_W  = 4;

   localparam logic [STEP_W-1:0] Q_STEP = 13'd1499;
   localparam logic [W-1:0]      Q_RES  = 11'd1499;
   localparam logic [CNT_W-1:0]  CNT_LAST = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True when an operand lies outside the residue range [0, Q-1].
   function automatic logic operand_bad(input logic [W-1:0] v);
      return (v >= Q_RES);
   endfunction

endpackage

// File: rtl/modmul_seq_1499_mod_csub.sv
// Combinational conditional subtract: y = (x >= Q) ? x - Q : x, in STEP_W bits.
module modmul_seq_1499_mod_csub
   import modmul_seq_1499_pkg::*;
(
   input  logic [STEP_W-1:0] x,
   output logic [STEP_W-1:0] y
);

   // Single reduction step toward the residue range.
   always_comb begin
      y = x;
      if (x >= Q_STEP) begin
         y = x - Q_STEP;
      end else begin
         y = x;
      end
   end

endmodule

// File: rtl/modmul_seq_1499.sv
// Interleaved (MSB-first) modular multiplier r = (a*b) mod 1499 with valid/ready on both sides.
// One multiplication in flight; W step cycles regardless of operand values.
module modmul_seq_1499
   import modmul_seq_1499_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         out_err
);

   state_t              state_r;
   state_t              state_next_s;
   logic [W-1:0]        a_r;
   logic [W-1:0]        b_r;
   logic                err_r;
   logic [W-1:0]        acc_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [W-1:0]        res_r;
   logic                res_err_r;
   logic                in_ready_r;
   logic                out_valid_r;

   logic                accept_s;
   logic                last_step_s;
   logic [STEP_W-1:0]   addend_s;
   logic [STEP_W-1:0]   step_sum_s;
   logic [STEP_W-1:0]   sub1_s;
   logic [STEP_W-1:0]   sub2_s;
   logic [W-1:0]        acc_next_s;
   logic                unused_hi_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_r     = res_r;
   assign out_err   = res_err_r;

   assign accept_s    = in_valid && in_ready_r;
   assign last_step_s = (cnt_r == 4'd0);

   // Step value 2*acc + (b[cnt] ? a : 0); at most 3Q-3, which fits STEP_W bits.
   always_comb begin
      addend_s = {STEP_W{1'b0}};
      if (b_r[cnt_r]) begin
         addend_s = {2'b00, a_r};
      end else begin
         addend_s = {STEP_W{1'b0}};
      end
      step_sum_s = {1'b0, acc_r, 1'b0} + addend_s;
   end

   modmul_seq_1499_mod_csub u_csub1 (
      .x (step_sum_s),
      .y (sub1_s)
   );

   modmul_seq_1499_mod_csub u_csub2 (
      .x (sub1_s),
      .y (sub2_s)
   );

   // Two subtracts bring the step value below Q, so the top bits are always zero.
   assign acc_next_s  = sub2_s[W-1:0];
   assign unused_hi_s = |sub2_s[STEP_W-1:W];

   // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_step_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register and handshake flags, registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_DONE);
      end
   end

   // Operand capture, accumulator/counter stepping and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         err_r     <= 1'b0;
         acc_r     <= {W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         res_r     <= {W{1'b0}};
         res_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  a_r   <= in_a;
                  b_r   <= in_b;
                  err_r <= operand_bad(in_a) | operand_bad(in_b);
                  acc_r <= {W{1'b0}};
                  cnt_r <= CNT_LAST;
               end
            end
            ST_RUN: begin
               acc_r <= acc_next_s;
               if (last_step_s) begin
                  res_r     <= err_r ? {W{1'b0}} : acc_next_s;
                  res_err_r <= err_r;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_DONE: begin
               res_r     <= res_r;
               res_err_r <= res_err_r;
            end
            default: begin
               acc_r <= {W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modmul_seq_1499.sv
// Directed self-checking bench for modmul_seq_1499: known products, range errors,
// backpressure, mid-run reset and a sampled sweep against an integer model.
module tb_modmul_seq_1499;

   localparam int QM       = 1499;
   localparam int LAT      = 11;   // edges after the accept edge; accept cycle + W RUN cycles = 12 clocks
   localparam int MAX_WAIT = 40;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_a;
   logic [10:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_r;
   logic        out_err;

   int errors = 0;
   int checks = 0;

   modmul_seq_1499 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE, check latency and result, then complete the handshake.
   task automatic run_op(input int a, input int b, input int exp_r, input int exp_err,
                         input string tag);
      int lat;
      check({tag, "_in_ready"}, int'(in_ready), 1);
      in_a     = 11'(a);
      in_b     = 11'(b);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < MAX_WAIT) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_r"}, int'(out_r), exp_r);
      check({tag, "_err"}, int'(out_err), exp_err);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_back_idle"}, int'({in_ready, out_valid}), 2);
   endtask

   initial begin
      int a;
      int b;
      int highs;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 11'd0;
      in_b      = 11'd0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_r", int'(out_r), 0);
      check("reset_out_err", int'(out_err), 0);
      rst = 1'b0;
      tick();

      run_op(3, 5, 15, 0, "mul_3x5");
      run_op(1498, 1498, 1, 0, "mul_max");
      run_op(0, 1234, 0, 0, "mul_zero");
      run_op(1000, 1000, 167, 0, "mul_1000");
      run_op(1498, 1, 1498, 0, "mul_max_by_1");
      run_op(1499, 7, 0, 1, "err_a");
      run_op(2, 2, 4, 0, "after_err");
      run_op(5, 2047, 0, 1, "err_b");

      // Backpressure: result must hold while out_ready stays low; new operands ignored.
      in_a     = 11'd123;
      in_b     = 11'd456;
      in_valid = 1'b1;
      tick();
      in_a = 11'd9;
      in_b = 11'd9;
      repeat (LAT) tick();
      for (int i = 0; i < 20; i++) begin
         check("bp_hold", int'({out_valid, in_ready, out_err}), 4);
         check("bp_r", int'(out_r), 625);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release", int'({in_ready, out_valid}), 2);

      // Reset during RUN aborts the op with no output.
      in_a     = 11'd7;
      in_b     = 11'd9;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_run_idle", int'({in_ready, out_valid}), 2);
      highs = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) highs++;
      end
      check("rst_run_no_output", highs, 0);
      run_op(2, 3, 6, 0, "after_rst");

      // Sampled sweep against the integer model, including range corners.
      run_op(1, 1498, 1498, 0, "sweep_corner1");
      run_op(1498, 0, 0, 0, "sweep_corner2");
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(0, QM - 1));
         b = int'($urandom_range(0, QM - 1));
         run_op(a, b, (a * b) % QM, 0, "sweep");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
